// File: rtl/queue_tail_ptr_responder_if.sv
// Shared payload types for the tail-pointer table and the AXI4-Lite bundle
// used by the enqueue engine to reach it.
package queue_tail_ptr_pkg;
    localparam int unsigned QUEUE_TAIL_POINTER_DATALEN = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [15:0] new_tail_ptr;
        logic [14:0] next_page_ptr;
        logic        malloc_approved;
    } queue_tail_pointer_write_t;

    typedef struct packed {
        logic [15:0] tail_ptr;
        logic [14:0] current_page_ptr;
        logic        current_page_valid;
    } queue_tail_pointer_read_t;
endpackage

interface AXI4Lite_intf #(
    parameter int unsigned DATALEN = 32,
    parameter int unsigned ADDRLEN = 12
);
    logic [ADDRLEN-1:0]   awaddr;
    logic                 awvalid;
    logic                 awready;
    logic [DATALEN-1:0]   wdata;
    logic [DATALEN/8-1:0] wstrb;
    logic                 wvalid;
    logic                 wready;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    logic [ADDRLEN-1:0]   araddr;
    logic                 arvalid;
    logic                 arready;
    logic [DATALEN-1:0]   rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/queue_tail_ptr_responder.sv
// Per-queue tail-pointer / current-page table served over AXI4-Lite, with
// page-release clears from the dequeue side and a walking clear after reset.
module queue_tail_ptr_responder
    import queue_tail_ptr_pkg::*;
#(
    parameter int unsigned NUM_QUEUES = 128,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                          clk,
    input  logic                          sreset,
    AXI4Lite_intf.slave                   axil,
    input  logic                          release_valid,
    input  logic [$clog2(NUM_QUEUES)-1:0] release_queue,
    output logic                          init_done
);
    localparam int unsigned IDX_W = $clog2(NUM_QUEUES);

    if ((64'(NUM_QUEUES) << 2) > (64'(1) << ADDR_WIDTH)) begin : g_param_check
        $error("queue_tail_ptr_responder: 4*NUM_QUEUES exceeds the address space");
    end

    typedef enum logic [1:0] {INIT, IDLE, WR_RESP, RD_RESP} state_t;

    state_t state;
    state_t state_next;

    logic [15:0] tail_ptr   [NUM_QUEUES];
    logic [14:0] page_ptr   [NUM_QUEUES];
    logic        page_valid [NUM_QUEUES];

    logic [IDX_W-1:0]         init_cnt;
    logic                     last_grant_rd;
    logic                     bvalid_q;
    logic                     rvalid_q;
    logic [1:0]               bresp_q;
    logic [1:0]               rresp_q;
    queue_tail_pointer_read_t rdata_q;

    logic awready_c;
    logic wready_c;
    logic arready_c;
    logic wr_fire_c;
    logic rd_fire_c;

    // Address decode: in range only if the whole word index fits the table
    logic [IDX_W-1:0]          wr_idx;
    logic [IDX_W-1:0]          rd_idx;
    logic                      wr_in_range;
    logic                      rd_in_range;
    logic                      wr_ok;
    logic                      rel_ok;
    queue_tail_pointer_write_t wr_word;
    queue_tail_pointer_read_t  rd_word;
    logic                      unused_addr_lsbs;

    assign wr_idx      = axil.awaddr[2 +: IDX_W];
    assign rd_idx      = axil.araddr[2 +: IDX_W];
    assign wr_in_range = 32'(axil.awaddr[ADDR_WIDTH-1:2]) < NUM_QUEUES;
    assign rd_in_range = 32'(axil.araddr[ADDR_WIDTH-1:2]) < NUM_QUEUES;
    assign wr_word     = queue_tail_pointer_write_t'(axil.wdata);
    assign wr_ok       = wr_in_range && (axil.wstrb == 4'hF);
    assign rd_word     = {tail_ptr[rd_idx], page_ptr[rd_idx], page_valid[rd_idx]};
    assign rel_ok      = release_valid && !sreset && (state != INIT)
                         && (32'(release_queue) < NUM_QUEUES);
    assign unused_addr_lsbs = ^{axil.awaddr[1:0], axil.araddr[1:0]};

    assign axil.awready = awready_c;
    assign axil.wready  = wready_c;
    assign axil.arready = arready_c;
    assign axil.bvalid  = bvalid_q;
    assign axil.bresp   = bresp_q;
    assign axil.rvalid  = rvalid_q;
    assign axil.rresp   = rresp_q;
    assign axil.rdata   = rdata_q;

    always_ff @(posedge clk) begin
        if (sreset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state and grants; readies are only ever raised in IDLE
    always_comb begin
        state_next = state;
        awready_c  = 1'b0;
        wready_c   = 1'b0;
        arready_c  = 1'b0;
        wr_fire_c  = 1'b0;
        rd_fire_c  = 1'b0;
        case (state)
            INIT: begin
                if (init_cnt == IDX_W'(NUM_QUEUES - 1)) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (!sreset) begin
                    if (axil.awvalid && axil.wvalid && (!axil.arvalid || last_grant_rd)) begin
                        awready_c  = 1'b1;
                        wready_c   = 1'b1;
                        wr_fire_c  = 1'b1;
                        state_next = WR_RESP;
                    end else if (axil.arvalid) begin
                        arready_c  = 1'b1;
                        rd_fire_c  = 1'b1;
                        state_next = RD_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (axil.bready) begin
                    state_next = IDLE;
                end
            end
            RD_RESP: begin
                if (axil.rready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            init_cnt      <= '0;
            init_done     <= 1'b0;
            bvalid_q      <= 1'b0;
            rvalid_q      <= 1'b0;
            last_grant_rd <= 1'b1;
            bresp_q       <= RESP_OKAY;
            rresp_q       <= RESP_OKAY;
            rdata_q       <= '0;
        end else begin
            init_cnt  <= (state == INIT) ? init_cnt + IDX_W'(1) : '0;
            init_done <= (state_next != INIT);
            bvalid_q  <= (state_next == WR_RESP);
            rvalid_q  <= (state_next == RD_RESP);
            if (wr_fire_c) begin
                bresp_q       <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                last_grant_rd <= 1'b0;
            end
            if (rd_fire_c) begin
                rdata_q       <= rd_in_range ? rd_word : '0;
                rresp_q       <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                last_grant_rd <= 1'b1;
            end
        end
    end

    // Table update: a malloc-approved write lands after the release so it wins
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            tail_ptr[init_cnt]   <= '0;
            page_ptr[init_cnt]   <= '0;
            page_valid[init_cnt] <= 1'b0;
        end else begin
            if (rel_ok) begin
                page_valid[release_queue] <= 1'b0;
            end
            if (wr_fire_c && wr_ok) begin
                tail_ptr[wr_idx] <= wr_word.new_tail_ptr;
                if (wr_word.malloc_approved) begin
                    page_ptr[wr_idx]   <= wr_word.next_page_ptr;
                    page_valid[wr_idx] <= 1'b1;
                end
            end
        end
    end
endmodule
